// File: rtl/alu_cmd_issuer_if.sv
// alu_cmd_issuer_if: command and response valid/ready channels of the ALU command issuer
interface alu_cmd_issuer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [4:0] rsp_data;
  logic [2:0] rsp_op;
  modport master (output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
                  input  cmd_ready, rsp_valid, rsp_data, rsp_op);
  modport slave  (input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
                  output cmd_ready, rsp_valid, rsp_data, rsp_op);
endinterface

// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: queues ALU commands, drives the ALU pins, waits a settle time and returns each result in order.
// Define ALU_ISSUE_CHECK_EN to add a reference model with rsp_mismatch / err_sticky outputs.
module alu_cmd_issuer #(
  parameter int FIFO_DEPTH    = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_cmd_issuer_if.slave   io,
  output logic [3:0]        alu_a,
  output logic [3:0]        alu_b,
  output logic              alu_s0,
  output logic              alu_s1,
  output logic              alu_s3,
  input  logic [4:0]        alu_out,
`ifdef ALU_ISSUE_CHECK_EN
  output logic              rsp_mismatch,
  output logic              err_sticky,
`endif
  output logic              busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, DRIVE, HOLD} state_t;
  state_t        state_q, state_d;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [CW-1:0] tmr_q, tmr_d;
  logic [10:0]   mem_q [FIFO_DEPTH];
  logic [10:0]   cmd_q, cmd_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [4:0]    rsp_data_q, rsp_data_d;
  logic [2:0]    rsp_op_q, rsp_op_d;
  logic          full, empty, push, pop, sample;
  always_comb begin
    full        = cnt_q == (AW+1)'(FIFO_DEPTH);
    empty       = cnt_q == '0;
    push        = io.cmd_valid && !full;
    pop         = !empty && (state_q == IDLE || (state_q == HOLD && io.rsp_ready));
    sample      = state_q == DRIVE && tmr_q == CW'(1);
    wr_d        = push ? wr_q + 1'b1 : wr_q;
    rd_d        = pop ? rd_q + 1'b1 : rd_q;
    cnt_d       = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    state_d     = state_q;
    tmr_d       = tmr_q;
    cmd_d       = cmd_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_op_d    = rsp_op_q;
    if (pop) begin
      cmd_d       = mem_q[rd_q];
      tmr_d       = CW'(SETTLE_CYCLES);
      rsp_valid_d = 1'b0;
      state_d     = DRIVE;
    end else if (state_q == DRIVE) begin
      tmr_d = tmr_q - CW'(1);
      if (sample) begin
        rsp_valid_d = 1'b1;
        rsp_data_d  = alu_out;
        rsp_op_d    = cmd_q[10:8];
        state_d     = HOLD;
      end
    end else if (state_q == HOLD && io.rsp_ready) begin
      rsp_valid_d = 1'b0;
      state_d     = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_q        <= '0;
      rd_q        <= '0;
      cnt_q       <= '0;
      tmr_q       <= '0;
      cmd_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_op_q    <= '0;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      cnt_q       <= cnt_d;
      tmr_q       <= tmr_d;
      cmd_q       <= cmd_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_op_q    <= rsp_op_d;
    end
  end
  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= {io.cmd_op, io.cmd_a, io.cmd_b};
  end
`ifdef ALU_ISSUE_CHECK_EN
  function automatic logic [4:0] ref_alu(input logic [10:0] c);
    logic [4:0] a, b;
    a = {1'b0, c[7:4]};
    b = {1'b0, c[3:0]};
    case (c[10:8])
      3'b000:  return a + b;
      3'b001:  return a + {1'b0, ~c[3:0]} + 5'd1;
      3'b010:  return a + 5'd1;
      3'b011:  return a + 5'd15;
      3'b100:  return a & b;
      3'b101:  return a | b;
      3'b110:  return a ^ b;
      default: return {2'b00, c[7:5]};
    endcase
  endfunction
  logic mis_q, mis_d, err_q, err_d;
  always_comb begin
    mis_d = sample ? alu_out != ref_alu(cmd_q) : mis_q;
    err_d = err_q || (sample && mis_d);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mis_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      mis_q <= mis_d;
      err_q <= err_d;
    end
  end
  assign rsp_mismatch = mis_q;
  assign err_sticky   = err_q;
`endif
  assign io.cmd_ready = !full;
  assign io.rsp_valid = rsp_valid_q;
  assign io.rsp_data  = rsp_data_q;
  assign io.rsp_op    = rsp_op_q;
  assign {alu_s3, alu_s0, alu_s1} = cmd_q[10:8];
  assign alu_a        = cmd_q[7:4];
  assign alu_b        = cmd_q[3:0];
  assign busy         = state_q != IDLE || !empty;
endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb_alu_cmd_issuer: directed table-driven bench with an attached 4-bit ALU and a stuck-at hook on result bit 0.
module tb_alu_cmd_issuer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] alu_a, alu_b;
  logic alu_s0, alu_s1, alu_s3, busy, stuck0 = 1'b0;
  logic [4:0] alu_out;
  int total = 0, bad = 0, cyc = 0;
`ifdef ALU_ISSUE_CHECK_EN
  logic rsp_mismatch, err_sticky;
`endif
  alu_cmd_issuer_if bus ();
  alu_cmd_issuer #(.FIFO_DEPTH(4), .SETTLE_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .io(bus),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s0(alu_s0), .alu_s1(alu_s1), .alu_s3(alu_s3),
    .alu_out(alu_out),
`ifdef ALU_ISSUE_CHECK_EN
    .rsp_mismatch(rsp_mismatch), .err_sticky(err_sticky),
`endif
    .busy(busy));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  function automatic logic [4:0] alu(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    case (op)
      3'b000:  return {1'b0, a} + {1'b0, b};
      3'b001:  return {1'b0, a} + {1'b0, ~b} + 5'd1;
      3'b010:  return {1'b0, a} + 5'd1;
      3'b011:  return {1'b0, a} + 5'd15;
      3'b100:  return {1'b0, a & b};
      3'b101:  return {1'b0, a | b};
      3'b110:  return {1'b0, a ^ b};
      default: return {2'b00, a[3:1]};
    endcase
  endfunction
  assign alu_out = alu({alu_s3, alu_s0, alu_s1}, alu_a, alu_b) | {4'b0, stuck0};
  typedef struct {
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [4:0] exp;
  } vec_t;
  vec_t tv[6];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask
  task automatic push(input vec_t v);
    int n = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op = v.op;
    bus.cmd_a = v.a;
    bus.cmd_b = v.b;
    while (!bus.cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("push_timeout", {31'b0, bus.cmd_ready}, 1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask
  task automatic get_rsp(output logic [4:0] d, output logic [2:0] o, output int t, output logic mis);
    int n = 0;
    while (!bus.rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("rsp_timeout", {31'b0, bus.rsp_valid}, 1);
    d = bus.rsp_data;
    o = bus.rsp_op;
    t = cyc;
    mis = 1'b0;
`ifdef ALU_ISSUE_CHECK_EN
    mis = rsp_mismatch;
`endif
    @(negedge clk);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [4:0] d, held;
    logic [2:0] o;
    logic mis, any_valid;
    int t, t_prev;
    tv[0] = '{3'b111, 4'b1011, 4'b1111, 5'b00101};
    tv[1] = '{3'b000, 4'b1011, 4'b1111, 5'b11010};
    tv[2] = '{3'b001, 4'b0011, 4'b0101, 5'b01110};
    tv[3] = '{3'b011, 4'b0000, 4'b0000, 5'b01111};
    tv[4] = '{3'b010, 4'b1111, 4'b0000, 5'b10000};
    tv[5] = '{3'b110, 4'b1011, 4'b1111, 5'b00100};
    bus.cmd_valid = 1'b0;
    bus.cmd_op = '0;
    bus.cmd_a = '0;
    bus.cmd_b = '0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outs", {alu_a, alu_b, alu_s3, alu_s0, alu_s1, bus.rsp_valid, bus.rsp_data, bus.rsp_op, busy}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", {31'b0, bus.cmd_ready}, 1);
    // single shift-right command, timing checked edge by edge
    push(tv[0]);
    @(negedge clk);
    chk("pop_sel", {alu_s3, alu_s0, alu_s1}, 3'b111);
    chk("pop_a", alu_a, 4'b1011);
    chk("pop_no_rsp", {31'b0, bus.rsp_valid}, 0);
    @(negedge clk);
    chk("first_valid", {31'b0, bus.rsp_valid}, 1);
    chk("first_data", bus.rsp_data, tv[0].exp);
    chk("first_op", bus.rsp_op, tv[0].op);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("first_done", {bus.rsp_valid, busy}, 0);
    // streamed table with ready high
    fork
      for (int i = 1; i < 6; i++) push(tv[i]);
      for (int i = 1; i < 6; i++) begin
        get_rsp(d, o, t, mis);
        chk($sformatf("stream_data%0d", i), d, tv[i].exp);
        chk($sformatf("stream_op%0d", i), o, tv[i].op);
      end
    join
    // backpressure: fill FIFO behind a held response
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) push(tv[i]);
    chk("full_ready_low", {31'b0, bus.cmd_ready}, 0);
    chk("hold_valid", {31'b0, bus.rsp_valid}, 1);
    held = bus.rsp_data;
    chk("hold_data", held, tv[0].exp);
    repeat (5) @(negedge clk);
    chk("hold_stable", bus.rsp_data, held);
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      get_rsp(d, o, t, mis);
      chk($sformatf("drain_data%0d", i), d, tv[i].exp);
      chk($sformatf("drain_op%0d", i), o, tv[i].op);
      if (i > 0) chk($sformatf("drain_gap%0d", i), t - t_prev, 2);
      t_prev = t;
    end
    chk("drain_idle", {31'b0, busy}, 0);
    chk("hold_alu_retained", {alu_s3, alu_s0, alu_s1, alu_a, alu_b}, {tv[4].op, tv[4].a, tv[4].b});
    // reset during DRIVE with three queued
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(tv[i]);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("pre_reset_drive", {bus.rsp_valid, busy}, 2'b01);
    rst_n = 1'b0;
    #1;
    chk("async_reset_alu", {alu_a, alu_b, alu_s3, alu_s0, alu_s1}, 0);
    chk("async_reset_rsp", {bus.rsp_valid, bus.rsp_data, bus.rsp_op, busy}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    any_valid = 1'b0;
    repeat (8) begin
      @(negedge clk);
      any_valid |= bus.rsp_valid;
    end
    chk("no_rsp_after_reset", {31'b0, any_valid}, 0);
    chk("empty_after_reset", {bus.cmd_ready, busy}, 2'b10);
    push(tv[5]);
    get_rsp(d, o, t, mis);
    chk("fresh_after_reset", {o, d}, {tv[5].op, tv[5].exp});
`ifdef ALU_ISSUE_CHECK_EN
    stuck0 = 1'b1;
    push('{3'b100, 4'b1010, 4'b0101, 5'b00000});
    get_rsp(d, o, t, mis);
    chk("stuck_data", d, 5'b00001);
    chk("stuck_mismatch", {31'b0, mis}, 1);
    stuck0 = 1'b0;
    push(tv[1]);
    get_rsp(d, o, t, mis);
    chk("clean_mismatch", {31'b0, mis}, 0);
    chk("err_sticky_held", {31'b0, err_sticky}, 1);
    rst_n = 1'b0;
    #1;
    chk("err_sticky_reset", {31'b0, err_sticky}, 0);
    @(negedge clk);
    rst_n = 1'b1;
`endif
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_cmd_issuer.md
Name: alu_cmd_issuer

Overview:
- Sequential initiator for the 4-bit combinational ALU (a, b, s0, s1, s3 in; 5-bit out).
- Accepts operation commands over a valid/ready interface and buffers them in a small FIFO.
- Drives each command onto the ALU pins and waits a programmable settle time.
- Captures the 5-bit result and returns it over a valid/ready response interface.

Parameters:
- FIFO_DEPTH, 4, command FIFO entries; power of 2, >= 2.
- SETTLE_CYCLES, 1, clock edges ALU inputs are held before the result is sampled; >= 1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  FIFO can accept a command.
- cmd_op  input  3  {s3,s0,s1}. Arithmetic (s3=0): 000 add, 001 sub, 010 inc, 011 dec. Logic (s3=1): 100 and, 101 or, 110 xor, 111 shift-right-by-1 of a.
- cmd_a  input  4  operand a.
- cmd_b  input  4  operand b.
- alu_a  output  4  registered operand a to the ALU.
- alu_b  output  4  registered operand b to the ALU.
- alu_s0  output  1  registered select s0.
- alu_s1  output  1  registered select s1.
- alu_s3  output  1  registered select s3.
- alu_out  input  5  ALU result; bit 4 is carry (logic ops give 0).
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts result.
- rsp_data  output  5  captured alu_out.
- rsp_op  output  3  op that produced rsp_data.
- busy  output  1  state != IDLE or FIFO non-empty.

Behaviour:
- Reset (rst_n low, asynchronous):
  - FIFO emptied; state IDLE; settle counter 0.
  - alu_a, alu_b, alu_s0, alu_s1, alu_s3 = 0.
  - rsp_valid = 0, rsp_data = 0, rsp_op = 0, busy = 0.
  - cmd_ready = 1 once reset is released.
- Reset mid-operation discards in-flight and queued commands. No response is emitted for them.
- cmd_ready = !full (registered count; no same-cycle bypass).
- Push occurs on cmd_valid && cmd_ready. When full, cmd_ready = 0 even if a pop happens in the same cycle.
- Push and pop in the same cycle while not full: both take effect and the count is unchanged.
- FSM states and transitions:
  - IDLE: if the FIFO is non-empty, pop the head, register it onto alu_*, load counter = SETTLE_CYCLES, go to DRIVE.
  - DRIVE: decrement the counter each edge. On the edge where it reaches 0, sample alu_out into rsp_data and the op into rsp_op, set rsp_valid = 1, go to HOLD.
  - HOLD: rsp_valid, rsp_data and rsp_op are held stable until rsp_ready.
    - On the handshake edge, if the FIFO is non-empty, pop the next command directly into DRIVE (back-to-back, no IDLE bubble) and clear rsp_valid.
    - Otherwise clear rsp_valid and go to IDLE.
- Latency: from the pop edge to rsp_valid high is SETTLE_CYCLES edges. Steady-state throughput is one result per SETTLE_CYCLES+1 cycles with rsp_ready tied high.
- alu_* outputs change only on a pop. They retain the last command's values in IDLE and HOLD.
- rsp_data is never altered while rsp_valid = 1.
- Results are returned strictly in command order.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. The count is log2(FIFO_DEPTH)+1 bits.

Optional Feature:
- Macro: ALU_ISSUE_CHECK_EN.
- Enabled:
  - An internal reference model computes the expected 5-bit result from the popped command, using the same op encoding.
    - sub = a + ~b + 1; dec = a + 4'b1111; shift-right gives bit3 = 0; logic ops give bit4 = 0.
  - Extra output rsp_mismatch (1 bit), valid with rsp_valid, is 1 if rsp_data differs from the model.
  - Extra output err_sticky (1 bit) sets on any mismatch and clears only on reset.
- Disabled: neither port exists and no model logic is built.

Test Plan:
- Reset, then push op=111, a=1011, b=1111 with the ALU attached and SETTLE_CYCLES=1 -> alu_s3/s0/s1 = 1/1/1 one edge after push; rsp_data = 00101 and rsp_op = 111 one edge after the pop edge.
- op=000 a=1011 b=1111 -> 11010. op=001 a=0011 b=0101 -> 01110. op=011 a=0000 -> 01111. op=010 a=1111 -> 10000. op=110 a=1011 b=1111 -> 00100. All returned in that order.
- Hold rsp_ready = 0 and push FIFO_DEPTH+1 commands -> cmd_ready drops after FIFO_DEPTH accepted (one extra is in HOLD); rsp_data stays stable. Release rsp_ready -> all results drain in order back-to-back; busy falls after the last handshake.
- Assert rst_n low during DRIVE with 3 commands queued -> all outputs read 0 immediately; no rsp_valid after release; FIFO is empty.
- With ALU_ISSUE_CHECK_EN, force alu_out bit 0 to stuck-at-1 and issue op=100 a=1010 b=0101 -> rsp_data = 00001, rsp_mismatch = 1, err_sticky stays 1 until reset.
